// File: rtl/fmap_bram_reader.sv
// Streams a row-major 8-bit feature map out of 256-bit display BRAM words as
// an AXI-Stream pixel flow, with one 2-cycle read bubble per word.
module fmap_bram_reader #(
  parameter int PIX_W     = 24,
  parameter int PIX_H     = 24,
  parameter int BASE_ADDR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [11:0]  bram_addr,
  output logic         bram_re,
  input  logic [255:0] bram_rdata,
  output logic [7:0]   m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  output logic         m_tuser,
  output logic         busy,
  output logic         frame_done
);

  localparam int NPIX        = PIX_W * PIX_H;
  localparam int TOTAL_WORDS = (NPIX + 31) / 32;
  localparam int PIX_CW      = $clog2(NPIX + 1);
  localparam int WORD_CW     = $clog2(TOTAL_WORDS + 1);
  localparam int COL_CW      = $clog2(PIX_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_READ   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  logic [1:0]         state;
  logic [WORD_CW-1:0] word_cnt;
  logic [PIX_CW-1:0]  pix_cnt;
  logic [COL_CW-1:0]  col_cnt;
  logic [4:0]         byte_idx;
  logic [255:0]       word_p1;
  logic               hs;
  logic               last_pix;
  logic               last_col;
  logic [11:0]        next_addr;

  assign hs        = (state == S_STREAM) && m_tready;
  assign last_pix  = (pix_cnt == PIX_CW'(NPIX - 1));
  assign last_col  = (col_cnt == COL_CW'(PIX_W - 1));
  assign next_addr = 12'(BASE_ADDR) + 12'(word_cnt) + 12'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      word_cnt   <= '0;
      pix_cnt    <= '0;
      col_cnt    <= '0;
      byte_idx   <= '0;
      bram_addr  <= '0;
      bram_re    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bram_re    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_READ;
            word_cnt  <= '0;
            pix_cnt   <= '0;
            col_cnt   <= '0;
            byte_idx  <= '0;
            bram_re   <= 1'b1;
            bram_addr <= 12'(BASE_ADDR);
          end
        end
        S_READ: state <= S_WAIT;
        S_WAIT: begin
          byte_idx <= '0;
          state    <= S_STREAM;
        end
        S_STREAM: begin
          if (hs) begin
            pix_cnt  <= pix_cnt + PIX_CW'(1);
            byte_idx <= byte_idx + 5'd1;
            col_cnt  <= last_col ? '0 : col_cnt + COL_CW'(1);
            // The final pixel wins over the word boundary so padding lanes are never shown
            if (last_pix) begin
              state      <= S_IDLE;
              frame_done <= 1'b1;
            end else if (byte_idx == 5'd31) begin
              word_cnt  <= word_cnt + WORD_CW'(1);
              bram_re   <= 1'b1;
              bram_addr <= next_addr;
              state     <= S_READ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // BRAM word capture, one cycle after the read strobe
  always_ff @(posedge clk) begin
    if (state == S_WAIT) word_p1 <= bram_rdata;
  end

  assign m_tvalid = (state == S_STREAM);
  assign m_tdata  = m_tvalid ? word_p1[{byte_idx, 3'b000} +: 8] : 8'd0;
  assign m_tlast  = m_tvalid && last_col;
  assign m_tuser  = m_tvalid && (pix_cnt == '0);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_fmap_bram_reader.sv
// Scoreboard bench for fmap_bram_reader: a 24x24 instance at base 0 and a
// 10x5 instance at base 100, each fed by its own one-cycle-latency BRAM model.
module tb_fmap_bram_reader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         m_tready = 1'b1;

  logic         a_start = 1'b0, s_start = 1'b0;
  logic [11:0]  a_addr, s_addr;
  logic         a_re, s_re;
  logic [255:0] a_rdata, s_rdata;
  logic [7:0]   a_tdata, s_tdata;
  logic         a_tvalid, s_tvalid, a_tlast, s_tlast, a_tuser, s_tuser;
  logic         a_busy, s_busy, a_done, s_done;

  always #5 clk = ~clk;

  fmap_bram_reader #(.PIX_W(24), .PIX_H(24), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(a_start),
    .bram_addr(a_addr), .bram_re(a_re), .bram_rdata(a_rdata),
    .m_tdata(a_tdata), .m_tvalid(a_tvalid), .m_tready(m_tready),
    .m_tlast(a_tlast), .m_tuser(a_tuser), .busy(a_busy), .frame_done(a_done));

  fmap_bram_reader #(.PIX_W(10), .PIX_H(5), .BASE_ADDR(100)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .bram_addr(s_addr), .bram_re(s_re), .bram_rdata(s_rdata),
    .m_tdata(s_tdata), .m_tvalid(s_tvalid), .m_tready(m_tready),
    .m_tlast(s_tlast), .m_tuser(s_tuser), .busy(s_busy), .frame_done(s_done));

  function automatic logic [255:0] fill(input logic [11:0] a);
    logic [255:0] w;
    for (int k = 0; k < 32; k++) w[8*k +: 8] = 8'((int'(a) * 32 + k) & 255);
    return w;
  endfunction

  // Data is only valid the cycle after a strobe; otherwise the bus carries junk
  always @(posedge clk) begin
    a_rdata <= a_re ? fill(a_addr) : {8{32'hDEADBEEF}};
    s_rdata <= s_re ? fill(s_addr) : {8{32'hDEADBEEF}};
  end

  logic sel = 1'b0;
  logic [7:0]  mon_data;
  logic        mon_valid, mon_last, mon_user, mon_re, mon_done, mon_busy;
  logic [11:0] mon_addr;
  always_comb begin
    mon_data  = sel ? s_tdata  : a_tdata;
    mon_valid = sel ? s_tvalid : a_tvalid;
    mon_last  = sel ? s_tlast  : a_tlast;
    mon_user  = sel ? s_tuser  : a_tuser;
    mon_re    = sel ? s_re     : a_re;
    mon_addr  = sel ? s_addr   : a_addr;
    mon_done  = sel ? s_done   : a_done;
    mon_busy  = sel ? s_busy   : a_busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  logic [9:0]  pq[$];
  logic [11:0] aq[$];
  logic        mon_en = 1'b0;
  logic        fd_due = 1'b0;
  logic        stalled_prev = 1'b0;
  logic [9:0]  held = '0;
  int          done_cnt = 0;
  int          re_cnt = 0;
  int          pix_seen = 0;
  int          exp_done = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      stalled_prev = 1'b0;
      fd_due       = 1'b0;
    end else begin
      if (fd_due) begin
        chk("frame_done", 32'(mon_done), 32'd1);
        if (mon_done) done_cnt++;
        fd_due = 1'b0;
      end else if (mon_done) begin
        chk("done_spurious", 32'd1, 32'd0);
      end
      if (mon_re) begin
        re_cnt++;
        if (aq.size() == 0) chk("re_extra", 32'd1, 32'd0);
        else chk("rd_addr", 32'(mon_addr), 32'(aq.pop_front()));
      end
      if (stalled_prev) begin
        chk("hold_vld", 32'(mon_valid), 32'd1);
        chk("hold_pix", 32'({mon_user, mon_last, mon_data}), 32'(held));
      end
      if (mon_valid && m_tready) begin
        if (pq.size() == 0) chk("extra_pix", 32'd1, 32'd0);
        else begin
          chk("pix", 32'({mon_user, mon_last, mon_data}), 32'(pq.pop_front()));
          pix_seen++;
          if (pq.size() == 0) fd_due = 1'b1;
        end
      end
      stalled_prev = mon_valid && !m_tready;
      held         = {mon_user, mon_last, mon_data};
    end
  end

  task automatic push_frame();
    int w, h, base;
    w    = sel ? 10 : 24;
    h    = sel ? 5 : 24;
    base = sel ? 100 : 0;
    pix_seen = 0;
    for (int p = 0; p < w * h; p++)
      pq.push_back({(p == 0), (p % w == w - 1), 8'((base * 32 + p) & 255)});
    for (int i = 0; i < (w * h + 31) / 32; i++) aq.push_back(12'(base + i));
    exp_done++;
  endtask

  // Called at posedge+1; leaves at posedge+1 of the cycle after the pulse
  task automatic pulse_start();
    if (sel) s_start = 1'b1; else a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic wait_frame(input int budget, input bit rnd, input bit late);
    bit ok = 0;
    bit late_done = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      a_start = 1'b0;
      s_start = 1'b0;
      if (rnd) m_tready = 1'($urandom_range(0, 1));
      if (late && !late_done && mon_valid && m_tready && pq.size() == 1) begin
        if (sel) s_start = 1'b1; else a_start = 1'b1;
        late_done = 1;
      end
      if (pq.size() == 0 && aq.size() == 0 && !fd_due && done_cnt == exp_done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("timeout", 32'd0, 32'd1);
    m_tready = 1'b1;
  endtask

  initial begin
    int r0;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_re", 32'(a_re), 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_vld", 32'(a_tvalid), 32'd0);
    chk("rst_data", 32'(a_tdata), 32'd0);
    chk("rst_lastuser", 32'({a_tlast, a_tuser}), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Nominal frame with latency probing
    push_frame();
    pulse_start();
    chk("lat_re_c1", 32'(a_re), 32'd1);
    chk("lat_busy_c1", 32'(a_busy), 32'd1);
    @(posedge clk); #1;
    chk("lat_vld_c2", 32'(a_tvalid), 32'd0);
    @(posedge clk); #1;
    chk("lat_vld_c3", 32'(a_tvalid), 32'd1);
    wait_frame(3000, 1'b0, 1'b0);
    chk("nom_done_cnt", 32'(done_cnt), 32'(exp_done));
    chk("nom_busy_end", 32'(a_busy), 32'd0);

    // Random backpressure
    push_frame();
    pulse_start();
    wait_frame(5000, 1'b1, 1'b0);
    chk("rnd_done_cnt", 32'(done_cnt), 32'(exp_done));

    // Stall from the first valid pixel
    push_frame();
    m_tready = 1'b0;
    pulse_start();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_tvalid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    chk("stall_first_vld", 32'(seen), 32'd1);
    r0 = re_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_vld", 32'(a_tvalid), 32'd1);
    chk("stall_data", 32'(a_tdata), 32'd0);
    chk("stall_user", 32'(a_tuser), 32'd1);
    chk("stall_no_reread", 32'(re_cnt), 32'(r0));
    m_tready = 1'b1;
    wait_frame(3000, 1'b0, 1'b0);

    // Extra starts at cycle 5 and in the final handshake cycle are ignored
    push_frame();
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    wait_frame(3000, 1'b0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    chk("late_start_busy", 32'(a_busy), 32'd0);
    chk("late_start_done", 32'(done_cnt), 32'(exp_done));

    // Small map with a partial final word
    sel = 1'b1;
    push_frame();
    pulse_start();
    wait_frame(1000, 1'b0, 1'b0);
    chk("small_pix", 32'(pix_seen), 32'd50);
    repeat (10) @(posedge clk);
    #1;
    chk("small_idle", 32'({s_busy, s_tvalid}), 32'd0);
    sel = 1'b0;

    // Asynchronous reset in the middle of the frame
    push_frame();
    pulse_start();
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (pix_seen == 200 && a_tvalid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    chk("reach_pix200", 32'(seen), 32'd1);
    chk("pix200_data", 32'(a_tdata), 32'd200);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("arst_vld", 32'(a_tvalid), 32'd0);
    chk("arst_data", 32'(a_tdata), 32'd0);
    chk("arst_busy", 32'(a_busy), 32'd0);
    chk("arst_re_addr", 32'({a_re, a_addr}), 32'd0);
    chk("arst_lastuser", 32'({a_tlast, a_tuser}), 32'd0);
    pq.delete();
    aq.delete();
    exp_done--;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_no_done", 32'(a_done), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", 32'(a_done), 32'd0);
    mon_en = 1'b1;
    push_frame();
    pulse_start();
    wait_frame(3000, 1'b0, 1'b0);
    chk("final_done_cnt", 32'(done_cnt), 32'(exp_done));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
